mips_datapath_memory_load_align: RTL
====================================

Name: mips_datapath_memory_load_align

Overview:
Parametrised load formatter sitting between the data-memory port and the writeback stage. It accepts a load request with size, signedness and byte offset, then issues one or two word reads to memory. It extracts and combines the addressed bytes (little-endian lanes) and zero- or sign-extends the result. Output uses a valid/ready handshake.

Parameters:
WORD_WIDTH, 32, data-path width in bits; multiple of 8, power-of-two byte count, >= 32
OFF_WIDTH, $clog2(WORD_WIDTH/8), byte-offset width (derived; not overridden)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  load request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_size  input  2  0=none, 1=byte, 2=half (16 b), 3=word (WORD_WIDTH b)
req_signed  input  1  1=sign-extend, 0=zero-extend
req_offset  input  OFF_WIDTH  byte offset within the addressed word
mem_req_valid  output  1  memory read request
mem_req_next  output  1  0=addressed word, 1=following word
mem_rsp_valid  input  1  memory read data valid
mem_rsp_data  input  WORD_WIDTH  memory read data
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WORD_WIDTH  aligned, extended load result
out_fault  output  1  misaligned access rejected (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; req_ready=1 and all other outputs 0, including out_data; captured request and beat registers cleared.
- Reset mid-operation aborts any transaction and drops late mem_rsp_valid; no output is produced.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: req_ready=1. On req_valid, latch size/signed/offset.
  - size=0: go to DONE with out_data=0 and no memory access.
  - Rejected misaligned request: go to DONE with out_data=0 and out_fault=1.
  - Otherwise go to BEAT0.
- BEAT0: mem_req_valid=1, mem_req_next=0. On mem_rsp_valid, latch the data. If offset+nbytes > WORD_WIDTH/8, go to BEAT1; otherwise go to DONE.
- BEAT1: mem_req_valid=1, mem_req_next=1. On mem_rsp_valid, go to DONE.
- mem_rsp_valid is ignored in IDLE and DONE.
- DONE: out_valid=1. out_data, out_fault and out_valid stay stable until out_ready=1, then go to IDLE. No new request is accepted in the same cycle.
- Byte selection:
  - Result byte i = word0 byte (offset+i) if offset+i < WORD_WIDTH/8, else word1 byte (offset+i-WORD_WIDTH/8).
  - nbytes: byte=1, half=2, word=WORD_WIDTH/8.
- Extension: upper bits = req_signed & msb of the selected field. A word load is passed through unchanged.
- Misaligned means offset mod nbytes != 0.
- Latency: request accepted at T, mem_req_valid at T+1. A response at T+1 gives out_valid at T+2. Each extra beat or response stall adds 1 cycle per cycle.
- out_data updates only on entry to DONE.

Optional Feature:
MIPS_LOAD_ALIGN_MISALIGNED_EN
- Defined: misaligned requests are serviced.
  - Within-word cases use one beat.
  - Word-crossing cases use two beats via BEAT1.
  - out_fault is always 0.
- Undefined: misaligned requests skip memory, go to DONE with out_data=0 and out_fault=1.
  - BEAT1 is unreachable and may be removed by synthesis.
  - Aligned requests behave identically in both builds.

Test Plan:
- Byte, signed, offset 3, rsp 0x80FF_FF12 at T+1 -> out_valid at T+2, out_data=0xFFFF_FF80, out_fault=0.
- Half, unsigned, offset 2, rsp 0x9ABC_1234 -> out_data=0x0000_9ABC.
- Word, offset 2, macro defined, word0=0x4433_2211, word1=0x8877_6655:
  - two beats, mem_req_next 0 then 1;
  - out_data=0x6655_4433.
- Same request with macro undefined -> no mem_req_valid, out_valid at T+1, out_data=0, out_fault=1.
- Backpressure: out_ready=0 for 3 cycles -> out_valid/out_data held, req_ready=0; out_ready=1 -> IDLE next cycle.
- reset_n pulsed low while in BEAT1 -> all outputs 0 immediately, state IDLE; stray mem_rsp_valid afterwards produces no out_valid.

Source files
------------

// File: rtl/mips_datapath_memory_load_align.sv
// Load formatter between the data-memory port and writeback: fetches one or two
// words, extracts little-endian bytes, zero/sign-extends. Optional build macro:
// MIPS_LOAD_ALIGN_MISALIGNED_EN services misaligned loads instead of faulting them.
module mips_datapath_memory_load_align #(
  parameter int WORD_WIDTH = 32,
  parameter int OFF_WIDTH  = $clog2(WORD_WIDTH / 8)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [OFF_WIDTH-1:0]  req_offset,
  output logic                  mem_req_valid,
  output logic                  mem_req_next,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_fault
);

  localparam int NB = WORD_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              size_q;
  logic                    sgn_q;
  logic [OFF_WIDTH-1:0]    off_q;
  logic [WORD_WIDTH-1:0]   word0_q;
  logic [WORD_WIDTH-1:0]   data_q;
  logic                    fault_q;
  logic                    req_reject;

  function automatic logic [OFF_WIDTH+1:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'd1:    nbytes = (OFF_WIDTH+2)'(1);
      2'd2:    nbytes = (OFF_WIDTH+2)'(2);
      2'd3:    nbytes = (OFF_WIDTH+2)'(NB);
      default: nbytes = '0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_WIDTH-1:0] off);
    case (sz)
      2'd2:    misaligned = off[0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] sz, input logic [OFF_WIDTH-1:0] off);
    crosses = ({2'b00, off} + nbytes(sz)) > (OFF_WIDTH+2)'(NB);
  endfunction

  // Treat {word1, word0} as one little-endian byte stream starting at the offset.
  function automatic logic [WORD_WIDTH-1:0] format(
    input logic [WORD_WIDTH-1:0] w0,
    input logic [WORD_WIDTH-1:0] w1,
    input logic [OFF_WIDTH-1:0]  off,
    input logic [1:0]            sz,
    input logic                  sgn
  );
    logic [2*WORD_WIDTH-1:0] cat;
    logic [WORD_WIDTH-1:0]   sel;
    cat = {w1, w0} >> {off, 3'b000};
    sel = cat[WORD_WIDTH-1:0];
    case (sz)
      2'd1:    format = {{(WORD_WIDTH-8){sgn & sel[7]}}, sel[7:0]};
      2'd2:    format = {{(WORD_WIDTH-16){sgn & sel[15]}}, sel[15:0]};
      2'd3:    format = sel;
      default: format = '0;
    endcase
  endfunction

`ifdef MIPS_LOAD_ALIGN_MISALIGNED_EN
  assign req_reject = 1'b0;
`else
  assign req_reject = misaligned(req_size, req_offset);
`endif

  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == BEAT0) || (state_q == BEAT1);
  assign mem_req_next  = (state_q == BEAT1);
  assign out_valid     = (state_q == DONE);
  assign out_data      = data_q;
  assign out_fault     = fault_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_size == 2'd0 || req_reject) state_d = DONE;
          else                                state_d = BEAT0;
        end
      end
      BEAT0: begin
        if (mem_rsp_valid) state_d = crosses(size_q, off_q) ? BEAT1 : DONE;
      end
      BEAT1: begin
        if (mem_rsp_valid) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      word0_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q <= req_size;
            sgn_q  <= req_signed;
            off_q  <= req_offset;
            if (req_size == 2'd0 || req_reject) begin
              data_q  <= '0;
              fault_q <= req_reject;
            end
          end
        end
        BEAT0: begin
          if (mem_rsp_valid) begin
            word0_q <= mem_rsp_data;
            if (!crosses(size_q, off_q)) begin
              data_q  <= format(mem_rsp_data, {WORD_WIDTH{1'b0}}, off_q, size_q, sgn_q);
              fault_q <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_rsp_valid) begin
            data_q  <= format(word0_q, mem_rsp_data, off_q, size_q, sgn_q);
            fault_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
